// File: rtl/axi_i2s2_pkg.sv
// Shared definitions for the AXI-I2S2 lite register file: register indices,
// response codes and the write/read channel state encodings.
package axi_i2s2_pkg;

  localparam int unsigned NUM_REGS    = 4;
  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_SAMPLE  = 1;
  localparam int unsigned REG_VOLUME  = 2;
  localparam int unsigned REG_SCRATCH = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_i2s2_lite_regs.sv
// AXI4-Lite responder holding the four AXI-I2S2 software registers
// (control, sample, volume, scratch).
// Ports: ACLK/ARESET (sync, active-high); S_AXI_* AXI4-Lite slave channels
// (single outstanding write and read, AW/W accepted independently);
// reg_ctrl/reg_sample/reg_volume register contents; wr_pulse one-cycle
// per-register write strobe, asserted the cycle after the commit.
module axi_i2s2_lite_regs
  import axi_i2s2_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_REG0_RESET       = 32'h0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     reg_ctrl,
  output logic [31:0]                     reg_sample,
  output logic [31:0]                     reg_volume,
  output logic [3:0]                      wr_pulse
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic [1:0]      aw_idx_q, aw_idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [3:0]      wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]   reg_q [NUM_REGS];
  logic [DW-1:0]   reg_d [NUM_REGS];

  // Protection bits, sub-word address bits and any upper address bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Write channel FSM plus strobed register update on commit.
  always_comb begin
    logic          aw_hs, w_hs, commit;
    logic [1:0]    cidx;
    logic [DW-1:0] cdata;
    logic [SW-1:0] cstrb;

    w_state_d  = w_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    reg_d      = reg_q;
    wr_pulse_d = '0;
    commit     = 1'b0;
    cidx       = aw_idx_q;
    cdata      = wdata_q;
    cstrb      = wstrb_q;
    aw_hs      = S_AXI_AWVALID && awready_q;
    w_hs       = S_AXI_WVALID && wready_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          cidx   = S_AXI_AWADDR[3:2];
          cdata  = S_AXI_WDATA;
          cstrb  = S_AXI_WSTRB;
        end else if (aw_hs) begin
          aw_idx_d  = S_AXI_AWADDR[3:2];
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit = 1'b1;
          cdata  = S_AXI_WDATA;
          cstrb  = S_AXI_WSTRB;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit = 1'b1;
          cidx   = S_AXI_AWADDR[3:2];
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      w_state_d        = W_RESP;
      wr_pulse_d[cidx] = 1'b1;
      for (int k = 0; k < int'(SW); k++) begin
        if (cstrb[k]) reg_d[cidx][8*k +: 8] = cdata[8*k +: 8];
      end
    end

    // Readiness follows the state being entered so the registered flags line up.
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read channel FSM; capture uses reg_q so a same-cycle write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d   = reg_q[S_AXI_ARADDR[3:2]];
          r_state_d = R_VALID;
        end
      end
      R_VALID: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_VALID);
  end

  // State and output registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      reg_q[0]   <= DW'(C_REG0_RESET);
      for (int i = 1; i < int'(NUM_REGS); i++) reg_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      reg_q      <= reg_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign reg_ctrl      = 32'(reg_q[REG_CTRL]);
  assign reg_sample    = 32'(reg_q[REG_SAMPLE]);
  assign reg_volume    = 32'(reg_q[REG_VOLUME]);
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_i2s2_lite_regs.sv
// Self-checking bench for axi_i2s2_lite_regs: directed scenarios followed by
// randomized reads/writes, all checked against a plain array model of the
// four registers.
module tb_axi_i2s2_lite_regs;

  localparam logic [31:0] REG0_RST = 32'hA5A5_0001;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] reg_ctrl;
  logic [31:0] reg_sample;
  logic [31:0] reg_volume;
  logic [3:0]  wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [4];

  always #5 ACLK = ~ACLK;

  axi_i2s2_lite_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_REG0_RESET(REG0_RST)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_ctrl(reg_ctrl), .reg_sample(reg_sample), .reg_volume(reg_volume),
    .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] reg_port(input int i);
    if (i == 0) return reg_ctrl;
    if (i == 1) return reg_sample;
    return reg_volume;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    model[0] = REG0_RST;
    model[1] = 32'h0;
    model[2] = 32'h0;
    model[3] = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'h0);
    chk({tag, "_wready"},  32'(S_AXI_WREADY),  32'h0);
    chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'h0);
    chk({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'h0);
    chk({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'h0);
    chk({tag, "_rdata"},   S_AXI_RDATA,        32'h0);
    chk({tag, "_pulse"},   32'(wr_pulse),      32'h0);
    chk({tag, "_ctrl"},    reg_ctrl,           REG0_RST);
    chk({tag, "_sample"},  reg_sample,         32'h0);
    chk({tag, "_volume"},  reg_volume,         32'h0);
  endtask

  // One write with independent AW/W start delays and a B-channel stall.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bstall);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_fire, w_fire;
    int cyc = 0;
    int idx = int'(addr[3:2]);
    logic [3:0] exp_pulse = 4'b0001 << idx;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 60) begin
        chk("write_timeout", 32'({aw_done, w_done}), 32'h3);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        return;
      end
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      if (aw_done) chk("awready_after_latch", 32'(S_AXI_AWREADY), 32'h0);
      if (w_done)  chk("wready_after_latch",  32'(S_AXI_WREADY),  32'h0);
      chk("bvalid_before_commit", 32'(S_AXI_BVALID), 32'h0);
      chk("pulse_before_commit",  32'(wr_pulse),     32'h0);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    model[idx] = merge(model[idx], data, strb);
    chk("bvalid_rise", 32'(S_AXI_BVALID), 32'h1);
    chk("bresp",       32'(S_AXI_BRESP),  32'h0);
    chk("wr_pulse",    32'(wr_pulse),     32'(exp_pulse));
    if (idx < 3) chk("reg_port", reg_port(idx), model[idx]);
    for (int s = 0; s < bstall; s++) begin
      tick();
      chk("bvalid_hold",  32'(S_AXI_BVALID),  32'h1);
      chk("awready_hold", 32'(S_AXI_AWREADY), 32'h0);
      chk("wready_hold",  32'(S_AXI_WREADY),  32'h0);
      chk("pulse_single", 32'(wr_pulse),      32'h0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", 32'(S_AXI_BVALID),  32'h0);
    chk("pulse_clear",  32'(wr_pulse),      32'h0);
    chk("awready_back", 32'(S_AXI_AWREADY), 32'h1);
  endtask

  // One read with an R-channel stall; returns the data seen.
  task automatic axi_read(input logic [3:0] addr, input int rstall, output logic [31:0] got);
    int cyc = 0;
    logic [31:0] exp;
    got = 32'h0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY) begin
      if (cyc > 60) begin
        chk("ar_timeout", 32'(S_AXI_ARREADY), 32'h1);
        S_AXI_ARVALID = 1'b0;
        return;
      end
      tick();
      cyc++;
    end
    exp = model[int'(addr[3:2])];
    tick();
    S_AXI_ARVALID = 1'b0;
    got = S_AXI_RDATA;
    chk("rvalid_rise", 32'(S_AXI_RVALID), 32'h1);
    chk("rdata",       S_AXI_RDATA,       exp);
    chk("rresp",       32'(S_AXI_RRESP),  32'h0);
    for (int s = 0; s < rstall; s++) begin
      tick();
      chk("rvalid_hold",  32'(S_AXI_RVALID),  32'h1);
      chk("rdata_hold",   S_AXI_RDATA,        exp);
      chk("arready_hold", 32'(S_AXI_ARREADY), 32'h0);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_clear", 32'(S_AXI_RVALID),  32'h0);
    chk("arready_back", 32'(S_AXI_ARREADY), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    ARESET = 1'b0;
    tick();

    // Sequential writes then reads of all four registers.
    for (int i = 0; i < 4; i++)
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, got);
      chk("seq_read_const", got, 32'(i + 1));
    end

    // W leads AW by three cycles.
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0, got);
    chk("w_first_const", got, 32'hDEADBEEF);

    // Partial byte strobes, with a sub-word address offset that is ignored.
    axi_write(4'hC, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(4'hE, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
    axi_read(4'hC, 0, got);
    chk("strobe_const", got, 32'h11BB33DD);

    // Zero strobe still pulses but leaves data alone.
    axi_write(4'h4, 32'hFFFFFFFF, 4'h0, 0, 2, 0);

    // Response backpressure on both channels.
    axi_write(4'h0, 32'h0000_00C3, 4'hF, 0, 0, 10);
    axi_read(4'h0, 10, got);
    chk("bp_const", got, 32'h0000_00C3);

    // Read capture and write commit to the same register in one cycle.
    axi_write(4'h4, 32'h5, 4'hF, 0, 0, 0);
    chk("coll_ready_aw", 32'(S_AXI_AWREADY), 32'h1);
    chk("coll_ready_ar", 32'(S_AXI_ARREADY), 32'h1);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4;  S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("coll_bvalid", 32'(S_AXI_BVALID), 32'h1);
    chk("coll_rvalid", 32'(S_AXI_RVALID), 32'h1);
    chk("coll_rdata",  S_AXI_RDATA,       32'h5);
    chk("coll_sample", reg_sample,        32'h9);
    model[1] = 32'h9;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    axi_read(4'h4, 0, got);
    chk("coll_after_const", got, 32'h9);

    // Reset while an address is latched and the data never arrives.
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    chk("rst_aw_ready", 32'(S_AXI_AWREADY), 32'h1);
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("rst_aw_latched", 32'(S_AXI_AWREADY), 32'h0);
    ARESET = 1'b1;
    tick();
    check_reset_outputs("midwr_reset");
    ARESET = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      chk("midwr_no_bvalid", 32'(S_AXI_BVALID), 32'h0);
    end
    axi_read(4'hC, 0, got);
    chk("midwr_scratch", got, 32'h0);
    axi_write(4'h8, 32'h0000_0777, 4'hF, 0, 1, 0);
    axi_read(4'h8, 0, got);

    // Randomized traffic against the array model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] a = 4'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1)
        axi_write(a, 32'($urandom), 4'($urandom_range(15, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(2, 0)));
      else
        axi_read(a, int'($urandom_range(2, 0)), got);
    end
    for (int i = 0; i < 3; i++) chk("final_port", reg_port(i), model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
